i2c_target_regfile: RTL and testbench
=====================================

Name: i2c_target_regfile

Overview:
- I2C target (slave) responder with a 256×8 register file, address DEV_ADDR (default 0x29, VL53L0X-compatible).
- Used as the on-board/bench counterpart of our I2C master ranging sequencer: accepts index writes, data writes and auto-incrementing reads.
- A host-side write port lets local logic preload result registers (e.g. 0x13 interrupt status, 0x1E/0x1F distance).
- Drives SDA open-drain via an enable; never drives SCL (no clock stretching).

Parameters:
DEV_ADDR, 7'h29, 7-bit target address matched against the first byte after START
FILTER_LEN, 4, fastclk cycles an input must be stable before the filtered level changes

Ports:
fastclk  input  1  system clock (25 MHz)
rstn  input  1  asynchronous active-low reset
scl_in  input  1  raw SCL pin level
sda_in  input  1  raw SDA pin level
sda_oe  output  1  1 = pull SDA low, 0 = release
host_we  input  1  host register write strobe
host_addr  input  8  host write index
host_wdata  input  8  host write data
wr_pulse  output  1  one-cycle pulse per byte written over I2C
wr_addr  output  8  index of that byte
wr_data  output  8  value of that byte
busy  output  1  1 between an addressed START and the following STOP/mismatch

Behaviour:
- Reset (async, rstn=0): sda_oe=0, wr_pulse=0, wr_addr=0, wr_data=0, busy=0, pointer=0, all registers 0x00, state IDLE, filtered SCL/SDA=1.
- Input path: 2-FF synchronizer per line, then a stability filter (level updates only after FILTER_LEN consecutive equal samples). All edge and condition detection uses the filtered levels.
- Conditions:
  - START = filtered SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - Sampling on SCL rise; SDA changes only on SCL fall.
- States: IDLE, ADDR, ADDR_ACK, INDEX, INDEX_ACK, WDATA, WDATA_ACK, RDATA, MACK, IGNORE.
- START (from any state, incl. repeated START) → ADDR, bit counter=7, sda_oe=0.
- STOP (from any state) → IDLE, sda_oe=0, busy=0.
- ADDR: shift 8 bits MSB first on SCL rises.
  - On 8th rise, if addr==DEV_ADDR → ADDR_ACK, busy=1.
  - Otherwise → IGNORE, no ACK.
- ACK timing: sda_oe=1 from the SCL fall after bit 8 until the SCL fall ending the 9th clock.
- ADDR_ACK: on that final fall go to INDEX (R/W=0) or RDATA (R/W=1).
  - For RDATA, load shift register with reg[pointer] on that same fall and drive bit 7 immediately.
- INDEX: 8 bits → pointer; ACK → WDATA.
- WDATA: 8 bits, ACK.
  - On 8th rise: reg[pointer]<=byte, wr_pulse=1 for one cycle, wr_addr=pointer, wr_data=byte, pointer+=1.
  - After ACK, further bytes continue writing.
- RDATA: on each SCL fall, sda_oe = ~current bit. After 8th bit's fall release SDA → MACK.
- MACK: sample SDA on SCL rise.
  - 0 (ACK): pointer+=1, load reg[pointer+1] at the ending fall → RDATA.
  - 1 (NACK): pointer+=1 → IGNORE.
- IGNORE: sda_oe=0; wait for START/STOP.
- Pointer is 8 bits, wraps 0xFF→0x00, and persists across transactions. This makes index-write + STOP + START + read return the written index.
- Simultaneous host_we and an I2C write to the same index in the same cycle: the I2C write wins. Host writes never affect the pointer.
- Read data is sampled into the shift register at load time; later host writes do not change a byte already being shifted.
- Reset mid-transfer releases SDA in the same cycle (async).

Test Plan:
- Write SYSRANGE_START: START, 0x52, 0x00, 0x01, STOP.
  - Required: ACK on all three bytes.
  - Required: wr_pulse once with wr_addr=0x00, wr_data=0x01; reg[0x00]=0x01.
- Host preloads reg[0x13]=0x07. Then START 0x52 0x13 STOP, START 0x53, read one byte with NACK, STOP.
  - Required: byte 0x07; SDA released during the 9th clock; busy=0 after STOP.
- Host preloads 0x1E=0x01, 0x1F=0x2C. Read 2 bytes from index 0x1E (ACK then NACK).
  - Required: 0x01 then 0x2C; pointer ends at 0x20.
- Address 0x2A sent.
  - Required: no ACK (SDA stays 1 on the 9th clock), no wr_pulse, busy=0; a following correct transaction still ACKs.
- Write index 0xFF, data 0xAA, 0xBB.
  - Required: reg[0xFF]=0xAA, reg[0x00]=0xBB (wrap).
- Glitches and reset mid-read:
  - 2-cycle SDA glitch while SCL high must not create START/STOP.
  - rstn asserted mid-read: sda_oe=0 immediately, and all registers read 0x00 afterwards.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target with 256x8 register file, auto-increment pointer and host preload port
`timescale 1ns/1ps
module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR   = 7'h29,
    parameter int         FILTER_LEN = 4
) (
    input  logic       fastclk,
    input  logic       rstn,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       wr_pulse,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_INDEX, ST_INDEX_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_MACK, ST_IGNORE
    } state_t;

    logic [1:0]    scl_s_q, sda_s_q;
    logic [CW-1:0] scl_cnt_q, sda_cnt_q;
    logic          scl_f_q, sda_f_q, scl_p_q, sda_p_q;

    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [7:0]    ptr_q;
    logic          ack_flag_q;
    logic          rw_q;
    logic          sda_oe_q, busy_q, wr_pulse_q;
    logic [7:0]    wr_addr_q, wr_data_q;
    logic [7:0]    regs_q [256];

    logic          scl_rise, scl_fall, start_c, stop_c;
    logic [7:0]    byte_in, rd_byte, rd_next;

    assign scl_rise = scl_f_q & ~scl_p_q;
    assign scl_fall = ~scl_f_q & scl_p_q;
    assign start_c  = sda_p_q & ~sda_f_q & scl_f_q & scl_p_q;
    assign stop_c   = ~sda_p_q & sda_f_q & scl_f_q & scl_p_q;
    assign byte_in  = {shift_q[6:0], sda_f_q};
    assign rd_byte  = regs_q[ptr_q];
    assign rd_next  = regs_q[ptr_q + 8'd1];

    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign wr_pulse = wr_pulse_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

    // Synchronise both pins, then only accept a new level after FILTER_LEN agreeing samples
    always_ff @(posedge fastclk or negedge rstn) begin
        if (!rstn) begin
            scl_s_q   <= 2'b11;
            sda_s_q   <= 2'b11;
            scl_cnt_q <= '0;
            sda_cnt_q <= '0;
            scl_f_q   <= 1'b1;
            sda_f_q   <= 1'b1;
            scl_p_q   <= 1'b1;
            sda_p_q   <= 1'b1;
        end else begin
            scl_s_q <= {scl_s_q[0], scl_in};
            sda_s_q <= {sda_s_q[0], sda_in};
            scl_p_q <= scl_f_q;
            sda_p_q <= sda_f_q;
            if (scl_s_q[1] == scl_f_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == CNT_MAX) begin
                scl_f_q   <= scl_s_q[1];
                scl_cnt_q <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + 1'b1;
            end
            if (sda_s_q[1] == sda_f_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == CNT_MAX) begin
                sda_f_q   <= sda_s_q[1];
                sda_cnt_q <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + 1'b1;
            end
        end
    end

    // Protocol FSM: bits sampled on SCL rise, SDA driven/released on SCL fall
    always_ff @(posedge fastclk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd7;
            shift_q    <= 8'h00;
            ptr_q      <= 8'h00;
            ack_flag_q <= 1'b0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
        end else begin
            wr_pulse_q <= 1'b0;
            if (stop_c) begin
                state_q    <= ST_IDLE;
                sda_oe_q   <= 1'b0;
                busy_q     <= 1'b0;
                ack_flag_q <= 1'b0;
            end else if (start_c) begin
                state_q    <= ST_ADDR;
                bit_cnt_q  <= 3'd7;
                sda_oe_q   <= 1'b0;
                ack_flag_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR: if (scl_rise) begin
                        shift_q <= byte_in;
                        if (bit_cnt_q == 3'd0) begin
                            if (byte_in[7:1] == DEV_ADDR) begin
                                state_q    <= ST_ADDR_ACK;
                                busy_q     <= 1'b1;
                                rw_q       <= byte_in[0];
                                ack_flag_q <= 1'b0;
                            end else begin
                                state_q <= ST_IGNORE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                        end
                    end
                    ST_INDEX: if (scl_rise) begin
                        shift_q <= byte_in;
                        if (bit_cnt_q == 3'd0) begin
                            ptr_q      <= byte_in;
                            state_q    <= ST_INDEX_ACK;
                            ack_flag_q <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                        end
                    end
                    ST_WDATA: if (scl_rise) begin
                        shift_q <= byte_in;
                        if (bit_cnt_q == 3'd0) begin
                            wr_pulse_q <= 1'b1;
                            wr_addr_q  <= ptr_q;
                            wr_data_q  <= byte_in;
                            ptr_q      <= ptr_q + 8'd1;
                            state_q    <= ST_WDATA_ACK;
                            ack_flag_q <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                        end
                    end
                    ST_ADDR_ACK, ST_INDEX_ACK, ST_WDATA_ACK: if (scl_fall) begin
                        if (!ack_flag_q) begin
                            // fall after bit 8: pull SDA low for the ACK clock
                            sda_oe_q   <= 1'b1;
                            ack_flag_q <= 1'b1;
                        end else begin
                            ack_flag_q <= 1'b0;
                            bit_cnt_q  <= 3'd7;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                state_q  <= ST_RDATA;
                                shift_q  <= rd_byte;
                                sda_oe_q <= ~rd_byte[7];
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= (state_q == ST_ADDR_ACK) ? ST_INDEX : ST_WDATA;
                            end
                        end
                    end
                    ST_RDATA: if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_q   <= 1'b0;
                            state_q    <= ST_MACK;
                            ack_flag_q <= 1'b0;
                        end else begin
                            sda_oe_q  <= ~shift_q[6];
                            shift_q   <= {shift_q[6:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                        end
                    end
                    ST_MACK: begin
                        if (scl_rise) begin
                            if (sda_f_q) begin
                                ptr_q   <= ptr_q + 8'd1;
                                state_q <= ST_IGNORE;
                            end else begin
                                ack_flag_q <= 1'b1;
                            end
                        end else if (scl_fall && ack_flag_q) begin
                            ack_flag_q <= 1'b0;
                            ptr_q      <= ptr_q + 8'd1;
                            shift_q    <= rd_next;
                            sda_oe_q   <= ~rd_next[7];
                            bit_cnt_q  <= 3'd7;
                            state_q    <= ST_RDATA;
                        end
                    end
                    ST_IGNORE: sda_oe_q <= 1'b0;
                    ST_IDLE:   sda_oe_q <= 1'b0;
                    default:   state_q  <= ST_IDLE;
                endcase
            end
        end
    end

    // Register file: host writes, then I2C writes so the bus wins a same-index collision
    always_ff @(posedge fastclk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 256; i++) regs_q[i] <= 8'h00;
        end else begin
            if (host_we)    regs_q[host_addr] <= host_wdata;
            if (wr_pulse_q) regs_q[wr_addr_q] <= wr_data_q;
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - directed bench for i2c_target_regfile with read/write scoreboards
`timescale 1ns/1ps
module tb_i2c_target_regfile;

    localparam int Q = 600;

    logic       fastclk = 1'b0;
    logic       rstn = 1'b0;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       scl_in, sda_in, sda_oe;
    logic       host_we = 1'b0;
    logic [7:0] host_addr = 8'h00, host_wdata = 8'h00;
    logic       wr_pulse, busy;
    logic [7:0] wr_addr, wr_data;

    int n_assert = 0;
    int n_fail = 0;
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    always #20 fastclk = ~fastclk;

    i2c_target_regfile #(.DEV_ADDR(7'h29), .FILTER_LEN(4)) dut (
        .fastclk(fastclk), .rstn(rstn), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // every write strobe must match the oldest expected write
    always @(negedge fastclk) begin
        if (rstn && wr_pulse === 1'b1) begin
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", {wr_addr, wr_data}, 16'hDEAD);
            end else begin
                check("wr_pulse", {wr_addr, wr_data}, exp_wr.pop_front());
            end
        end
    end

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge fastclk);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge fastclk);
        host_we = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b, input bit glitch);
        sda_m = b; #Q;
        scl_m = 1'b1; #Q;
        if (glitch) begin
            @(negedge fastclk);
            sda_m = ~b;
            repeat (2) @(negedge fastclk);
            sda_m = b;
        end
        #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b, output logic oe);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        b = sda_in; oe = sda_oe;
        #Q;
        scl_m = 1'b0; #Q;
    endtask

    // send a byte and compare the 9th-clock line level (0 = ACK)
    task automatic send_chk(input logic [7:0] d, input logic exp_line, input string tag, input int gbit);
        logic b, oe;
        for (int i = 7; i >= 0; i--) write_bit(d[i], gbit == i);
        read_bit(b, oe);
        check(tag, 16'(b), 16'(exp_line));
    endtask

    // read a byte, answer with ACK/NACK, check data and that SDA is released on the 9th clock
    task automatic read_chk(input logic master_ack, input string tag);
        logic [7:0] d;
        logic b, oe, oe9;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b, oe);
            d[i] = b;
        end
        sda_m = master_ack ? 1'b0 : 1'b1; #Q;
        scl_m = 1'b1; #Q;
        oe9 = sda_oe;
        #Q;
        scl_m = 1'b0; #Q;
        if (exp_rd.size() == 0) check({tag, "_noexp"}, 16'(d), 16'hBEEF);
        else check(tag, 16'(d), 16'(exp_rd.pop_front()));
        check({tag, "_oe9"}, 16'(oe9), 16'd0);
    endtask

    task automatic set_index(input logic [7:0] idx);
        i2c_start();
        send_chk(8'h52, 1'b0, "idx_addr_ack", -1);
        send_chk(idx, 1'b0, "idx_ack", -1);
        i2c_stop();
    endtask

    initial begin
        // reset state
        repeat (5) @(negedge fastclk);
        check("rst_sda_oe", 16'(sda_oe), 16'd0);
        check("rst_wr_pulse", 16'(wr_pulse), 16'd0);
        check("rst_wr_addr", 16'(wr_addr), 16'd0);
        check("rst_wr_data", 16'(wr_data), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        rstn = 1'b1;
        repeat (20) @(negedge fastclk);

        // SYSRANGE_START write
        exp_wr.push_back({8'h00, 8'h01});
        i2c_start();
        send_chk(8'h52, 1'b0, "t1_addr_ack", -1);
        send_chk(8'h00, 1'b0, "t1_idx_ack", -1);
        send_chk(8'h01, 1'b0, "t1_data_ack", -1);
        check("t1_busy", 16'(busy), 16'd1);
        i2c_stop();
        check("t1_busy_after", 16'(busy), 16'd0);
        check("t1_wr_drained", 16'(exp_wr.size()), 16'd0);
        set_index(8'h00);
        i2c_start();
        send_chk(8'h53, 1'b0, "t1_rd_addr_ack", -1);
        exp_rd.push_back(8'h01);
        read_chk(1'b0, "t1_reg00");
        i2c_stop();

        // host preload of interrupt status, single read
        host_write(8'h13, 8'h07);
        set_index(8'h13);
        i2c_start();
        send_chk(8'h53, 1'b0, "t2_addr_ack", -1);
        exp_rd.push_back(8'h07);
        read_chk(1'b0, "t2_reg13");
        i2c_stop();
        check("t2_busy_after", 16'(busy), 16'd0);

        // two-byte distance read, then pointer continuation
        host_write(8'h1E, 8'h01);
        host_write(8'h1F, 8'h2C);
        host_write(8'h20, 8'h5A);
        set_index(8'h1E);
        i2c_start();
        send_chk(8'h53, 1'b0, "t3_addr_ack", -1);
        exp_rd.push_back(8'h01);
        read_chk(1'b1, "t3_reg1e");
        exp_rd.push_back(8'h2C);
        read_chk(1'b0, "t3_reg1f");
        i2c_stop();
        i2c_start();
        send_chk(8'h53, 1'b0, "t3_addr2_ack", -1);
        exp_rd.push_back(8'h5A);
        read_chk(1'b0, "t3_ptr20");
        i2c_stop();

        // wrong address, then a correct transaction
        i2c_start();
        send_chk(8'h54, 1'b1, "t4_noack", -1);
        check("t4_busy", 16'(busy), 16'd0);
        i2c_stop();
        i2c_start();
        send_chk(8'h52, 1'b0, "t4_addr_ack", -1);
        send_chk(8'h13, 1'b0, "t4_idx_ack", -1);
        i2c_stop();

        // pointer wrap on write and read
        exp_wr.push_back({8'hFF, 8'hAA});
        exp_wr.push_back({8'h00, 8'hBB});
        i2c_start();
        send_chk(8'h52, 1'b0, "t5_addr_ack", -1);
        send_chk(8'hFF, 1'b0, "t5_idx_ack", -1);
        send_chk(8'hAA, 1'b0, "t5_d0_ack", -1);
        send_chk(8'hBB, 1'b0, "t5_d1_ack", -1);
        i2c_stop();
        set_index(8'hFF);
        i2c_start();
        send_chk(8'h53, 1'b0, "t5_rd_addr_ack", -1);
        exp_rd.push_back(8'hAA);
        read_chk(1'b1, "t5_regff");
        exp_rd.push_back(8'hBB);
        read_chk(1'b0, "t5_reg00");
        i2c_stop();

        // short SDA glitches while SCL high (fake START on a 1 bit, fake STOP on a 0 bit)
        exp_wr.push_back({8'h40, 8'h33});
        i2c_start();
        send_chk(8'h52, 1'b0, "t6_addr_ack", -1);
        send_chk(8'h40, 1'b0, "t6_idx_ack", 6);
        send_chk(8'h33, 1'b0, "t6_data_ack", 2);
        check("t6_busy", 16'(busy), 16'd1);
        i2c_stop();
        check("t6_wr_drained", 16'(exp_wr.size()), 16'd0);

        // reset while the target is driving read data
        host_write(8'h50, 8'h00);
        set_index(8'h50);
        i2c_start();
        send_chk(8'h53, 1'b0, "t7_addr_ack", -1);
        check("t7_driving", 16'(sda_oe), 16'd1);
        rstn = 1'b0;
        #1;
        check("t7_oe_async", 16'(sda_oe), 16'd0);
        check("t7_busy_rst", 16'(busy), 16'd0);
        repeat (4) @(negedge fastclk);
        rstn = 1'b1;
        repeat (4) @(negedge fastclk);
        i2c_stop();
        set_index(8'h00);
        i2c_start();
        send_chk(8'h53, 1'b0, "t7_rd_addr_ack", -1);
        exp_rd.push_back(8'h00);
        read_chk(1'b1, "t7_reg00");
        exp_rd.push_back(8'h00);
        read_chk(1'b0, "t7_reg01");
        i2c_stop();
        set_index(8'h1E);
        i2c_start();
        send_chk(8'h53, 1'b0, "t7_rd2_addr_ack", -1);
        exp_rd.push_back(8'h00);
        read_chk(1'b1, "t7_reg1e");
        exp_rd.push_back(8'h00);
        read_chk(1'b0, "t7_reg1f");
        i2c_stop();

        check("end_wr_queue", 16'(exp_wr.size()), 16'd0);
        check("end_rd_queue", 16'(exp_rd.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
